fault_dict_diagnoser: RTL
=========================

// Module: fault_dict_diagnoser
// PURPOSE
//  Reader side of the fault-dictionary flow: holds a loaded fault dictionary (one pass/fail syndrome per
//  collapsed fault) and diagnoses a device under test. Collects the observed per-pattern fail bits serially,
//  then scans the dictionary and streams out the index of every fault whose syndrome matches exactly.
//  Sits between the tester response compare logic and the diagnosis log / host.
// PARAMETERS
//  TEST_COUNT  129   patterns per syndrome; syndrome bit i = result of pattern i (1 = fail)
//  NUM_FAULTS  1798  dictionary entries (collapsed fault list length)
//  IDXW        $clog2(NUM_FAULTS)  fault index width
//  DISTW       $clog2(TEST_COUNT+1) Hamming distance width
// PORTS
//  clk          in   1           clock
//  rst          in   1           asynchronous, active-high reset
//  load_we      in   1           write dictionary entry; accepted only when busy==0
//  load_addr    in   IDXW        entry index; values >= NUM_FAULTS ignored
//  load_syn     in   TEST_COUNT  entry syndrome
//  obs_valid    in   1           observed fail bit valid
//  obs_bit      in   1           fail bit for next pattern (pattern 0 first)
//  obs_ready    out  1           1 in COLLECT
//  m_valid      out  1           match index valid
//  m_index      out  IDXW        matching fault index
//  m_ready      in   1           downstream accepts match
//  busy         out  1           1 in SCAN/DRAIN
//  done         out  1           1-cycle pulse at end of diagnosis
//  match_count  out  IDXW+1      exact matches of last diagnosis; valid from done until next done
//  pass_flag    out  1           last observation was all-zero (no failing pattern)
//  best_index   out  IDXW        nearest entry (FDIAG_HAMMING_EN only)
//  best_dist    out  DISTW       its Hamming distance (FDIAG_HAMMING_EN only)
// BEHAVIOUR
//  - Reset: state=COLLECT, bit counter=0, obs register=0, all outputs 0 except obs_ready=1. Dictionary
//    contents NOT cleared. Reset mid-SCAN aborts; pending m_valid dropped; no done.
//  - COLLECT: obs_valid&&obs_ready shifts obs_bit into position cnt; cnt++. On acceptance of bit
//    TEST_COUNT-1: if collected syndrome == 0 -> done=1, pass_flag=1, match_count=0 next cycle, stay
//    COLLECT (no scan); else -> SCAN, pass_flag=0, match_count cleared, addr=0. obs_ready=0 outside COLLECT.
//  - SCAN: dictionary is synchronous-read RAM, 1-cycle latency; one entry issued per cycle, compare stage
//    registered. Exact match loads m_valid=1, m_index=entry; match_count++.
//  - Backpressure: while m_valid && !m_ready, read issue and compare stall (no entry skipped or duplicated).
//    m_index stable while m_valid=1. Transfer when m_valid&&m_ready.
//  - DRAIN: after last entry issued, wait for compare pipe empty and final match accepted, then done=1
//    for one cycle, state -> COLLECT, cnt=0.
//  - Latency: with m_ready=1, done asserts exactly NUM_FAULTS+2 cycles after the SCAN entry cycle.
//  - load_we while busy=1 is dropped silently; load in COLLECT mid-collection is allowed.
//  - match_count saturates at NUM_FAULTS (cannot exceed by construction).
// CONFIGURATION
//  FDIAG_HAMMING_EN defined: compare stage also computes popcount(obs ^ entry); tracks minimum distance,
//    strict-less update so ties keep the lowest index; best_index/best_dist valid with done, held until
//    next done. Pass case (no scan): best_dist=0, best_index=0.
//  Not defined: no popcount logic; best_index and best_dist tied to 0.
// TESTING (TEST_COUNT=8, NUM_FAULTS=4 unless stated)
//  1 Load {0:8'h01,1:8'h81,2:8'h81,3:8'hF0}; observe 8'h81 (bit0 first), m_ready=1 -> m_index 1 then 2,
//    match_count=2, done exactly 6 cycles after SCAN entry.
//  2 Same dictionary, observe 8'h00 -> done 1 cycle after 8th bit, pass_flag=1, match_count=0, m_valid never.
//  3 Observe 8'h81, m_ready held 0 for 10 cycles after first m_valid -> m_index=1 stable, then 1,2 in order,
//    count=2, no duplicates.
//  4 load_we to addr 1 with 8'h00 during SCAN -> ignored; rescan of 8'h81 still reports 1,2.
//  5 Assert rst during SCAN -> obs_ready=1, m_valid=0, done never; dictionary retained, next 8'h01 -> index 0.
//  6 FDIAG_HAMMING_EN: dictionary {8'h0F,8'h07,8'h03,8'hFF}, observe 8'h01 -> match_count=0,
//    best_index=2, best_dist=1; undefined build -> best_* = 0.

Source files
------------

// File: rtl/fault_dict_diagnoser_if.sv
// Observation (fail-bit) stream into the diagnoser and matching-fault index stream out of it.
interface fault_dict_diagnoser_if #(
   parameter int IDXW = 11
);
   logic            obs_valid;
   logic            obs_bit;
   logic            obs_ready;
   logic            m_valid;
   logic [IDXW-1:0] m_index;
   logic            m_ready;

   modport master (
      input  obs_valid,
      input  obs_bit,
      input  m_ready,
      output obs_ready,
      output m_valid,
      output m_index
   );

   modport slave (
      output obs_valid,
      output obs_bit,
      output m_ready,
      input  obs_ready,
      input  m_valid,
      input  m_index
   );
endinterface

// File: rtl/fault_dict_diagnoser.sv
// Fault-dictionary diagnoser: collects an observed syndrome, scans the dictionary, streams exact matches.
// Define FDIAG_HAMMING_EN to also report the nearest dictionary entry (best_index/best_dist).
module fault_dict_diagnoser #(
   parameter int TEST_COUNT = 129,
   parameter int NUM_FAULTS = 1798,
   parameter int IDXW       = $clog2(NUM_FAULTS),
   parameter int DISTW      = $clog2(TEST_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_we,
   input  logic [IDXW-1:0]       load_addr,
   input  logic [TEST_COUNT-1:0] load_syn,
   fault_dict_diagnoser_if.master mif,
   output logic                  busy,
   output logic                  done,
   output logic [IDXW:0]         match_count,
   output logic                  pass_flag,
   output logic [IDXW-1:0]       best_index,
   output logic [DISTW-1:0]      best_dist
);

   localparam int              CNTW         = (TEST_COUNT > 1) ? $clog2(TEST_COUNT) : 1;
   localparam logic [CNTW-1:0] LAST_BIT     = CNTW'(TEST_COUNT - 1);
   localparam logic [IDXW-1:0] LAST_IDX     = IDXW'(NUM_FAULTS - 1);
   localparam logic [IDXW:0]   NUM_FAULTS_W = (IDXW + 1)'(NUM_FAULTS);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SCAN    = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic [TEST_COUNT-1:0] obs_q, obs_d;
   logic [IDXW-1:0]       addr_q, addr_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [IDXW-1:0]       rd_idx_q, rd_idx_d;
   logic                  m_valid_q, m_valid_d;
   logic [IDXW-1:0]       m_index_q, m_index_d;
   logic [IDXW:0]         match_count_q, match_count_d;
   logic                  pass_flag_q, pass_flag_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  obs_ready_q, obs_ready_d;

   logic                  issue;
   logic                  stall;
   logic                  load_ok;

   logic [TEST_COUNT-1:0] dict_mem [NUM_FAULTS];
   logic [TEST_COUNT-1:0] ram_rdata;

   assign load_ok = load_we && !busy_q && ({1'b0, load_addr} < NUM_FAULTS_W);

   // Dictionary RAM: never reset, written only while idle, read one entry per issue slot.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         dict_mem[load_addr] <= load_syn;
      end
      if (issue) begin
         ram_rdata <= dict_mem[addr_q];
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      obs_d         = obs_q;
      addr_d        = addr_q;
      rd_vld_d      = rd_vld_q;
      rd_idx_d      = rd_idx_q;
      m_valid_d     = m_valid_q;
      m_index_d     = m_index_q;
      match_count_d = match_count_q;
      pass_flag_d   = pass_flag_q;
      done_d        = 1'b0;
      issue         = 1'b0;
      stall         = m_valid_q && !mif.m_ready;

      case (state_q)
         COLLECT: begin
            if (mif.obs_valid && obs_ready_q) begin
               obs_d[cnt_q] = mif.obs_bit;
               if (cnt_q == LAST_BIT) begin
                  cnt_d         = '0;
                  match_count_d = '0;
                  if (obs_d == '0) begin
                     done_d      = 1'b1;
                     pass_flag_d = 1'b1;
                  end else begin
                     state_d     = SCAN;
                     pass_flag_d = 1'b0;
                     addr_d      = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         SCAN: begin
            if (!stall) begin
               issue    = 1'b1;
               rd_idx_d = addr_q;
               if (addr_q == LAST_IDX) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            // Finish only once the last read has been compared and its match (if any) accepted.
            if (!rd_vld_q && !stall) begin
               done_d  = 1'b1;
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      if (!stall) begin
         rd_vld_d  = issue;
         m_valid_d = 1'b0;
         if (rd_vld_q && (ram_rdata == obs_q)) begin
            m_valid_d = 1'b1;
            m_index_d = rd_idx_q;
            if (match_count_q != NUM_FAULTS_W) begin
               match_count_d = match_count_q + 1'b1;
            end
         end
      end

      busy_d      = (state_d != COLLECT);
      obs_ready_d = (state_d == COLLECT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= COLLECT;
         cnt_q         <= '0;
         obs_q         <= '0;
         addr_q        <= '0;
         rd_vld_q      <= 1'b0;
         rd_idx_q      <= '0;
         m_valid_q     <= 1'b0;
         m_index_q     <= '0;
         match_count_q <= '0;
         pass_flag_q   <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         obs_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         obs_q         <= obs_d;
         addr_q        <= addr_d;
         rd_vld_q      <= rd_vld_d;
         rd_idx_q      <= rd_idx_d;
         m_valid_q     <= m_valid_d;
         m_index_q     <= m_index_d;
         match_count_q <= match_count_d;
         pass_flag_q   <= pass_flag_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         obs_ready_q   <= obs_ready_d;
      end
   end

   assign mif.obs_ready = obs_ready_q;
   assign mif.m_valid   = m_valid_q;
   assign mif.m_index   = m_index_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign match_count   = match_count_q;
   assign pass_flag     = pass_flag_q;

`ifdef FDIAG_HAMMING_EN
   logic [TEST_COUNT-1:0] diff;
   logic [DISTW-1:0]      cur_dist;
   logic [DISTW-1:0]      run_dist_q, run_dist_d;
   logic [IDXW-1:0]       run_idx_q, run_idx_d;
   logic [DISTW-1:0]      best_dist_q, best_dist_d;
   logic [IDXW-1:0]       best_idx_q, best_idx_d;
   logic                  scan_start;
   logic                  pass_done;
   logic                  scan_done;

   assign diff       = obs_q ^ ram_rdata;
   assign scan_start = (state_q == COLLECT) && (state_d == SCAN);
   assign pass_done  = done_d && (state_q == COLLECT);
   assign scan_done  = done_d && (state_q == DRAIN);

   // Running minimum uses strict less-than so the lowest index wins ties.
   always_comb begin
      cur_dist = '0;
      for (int i = 0; i < TEST_COUNT; i++) begin
         cur_dist = cur_dist + DISTW'(diff[i]);
      end
      run_dist_d  = run_dist_q;
      run_idx_d   = run_idx_q;
      best_dist_d = best_dist_q;
      best_idx_d  = best_idx_q;
      if (scan_start) begin
         run_dist_d = '1;
         run_idx_d  = '0;
      end else if (rd_vld_q && !stall && (cur_dist < run_dist_q)) begin
         run_dist_d = cur_dist;
         run_idx_d  = rd_idx_q;
      end
      if (pass_done) begin
         best_dist_d = '0;
         best_idx_d  = '0;
      end else if (scan_done) begin
         best_dist_d = run_dist_q;
         best_idx_d  = run_idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_dist_q  <= '1;
         run_idx_q   <= '0;
         best_dist_q <= '0;
         best_idx_q  <= '0;
      end else begin
         run_dist_q  <= run_dist_d;
         run_idx_q   <= run_idx_d;
         best_dist_q <= best_dist_d;
         best_idx_q  <= best_idx_d;
      end
   end

   assign best_index = best_idx_q;
   assign best_dist  = best_dist_q;
`else
   assign best_index = '0;
   assign best_dist  = '0;
`endif

endmodule
